// File: rtl/branch_sequencer.sv
// Branch sequencer: turns a taken branch-unit result into a registered redirect handshake
// to the PC module. Define BRANCH_DELAY_SLOT_EN to retire one delay-slot instruction first.
module branch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        br_link,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic        instr_advance,
    input  logic        fetch_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        misalign,
    output logic        overlap_err,
    output logic [15:0] taken_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SLOT     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam state_t      TAKEN_STATE = ST_SLOT;
    localparam logic [31:0] LINK_OFFSET = 32'd8;
`else
    localparam state_t      TAKEN_STATE = ST_REDIRECT;
    localparam logic [31:0] LINK_OFFSET = 32'd4;
`endif

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        busy_q, busy_d;
    logic        link_we_q, link_we_d;
    logic [31:0] link_data_q, link_data_d;
    logic        misalign_q, misalign_d;
    logic        overlap_err_q, overlap_err_d;
    logic [15:0] taken_count_q, taken_count_d;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        link_data_d   = link_data_q;
        overlap_err_d = overlap_err_q;
        taken_count_d = taken_count_q;
        link_we_d     = 1'b0;
        misalign_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    // Link is written for taken and not-taken branches alike.
                    if (br_link) begin
                        link_we_d   = 1'b1;
                        link_data_d = br_pc + LINK_OFFSET;
                    end
                    if (br_taken) begin
                        target_d   = {br_target[31:2], 2'b00};
                        misalign_d = |br_target[1:0];
                        state_d    = TAKEN_STATE;
                    end
                end
            end
            ST_SLOT: begin
                if (instr_advance) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (fetch_ready) begin
                    state_d       = ST_IDLE;
                    taken_count_d = taken_count_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A second branch result while one is in flight is dropped and flagged.
        if (br_valid && (state_q != ST_IDLE)) begin
            overlap_err_d = 1'b1;
        end

        redirect_valid_d = (state_d == ST_REDIRECT);
        redirect_pc_d    = (state_d == ST_REDIRECT) ? target_d : 32'd0;
        flush_d          = (state_d == ST_REDIRECT) && (state_q != ST_REDIRECT);
        stall_d          = (state_d == ST_REDIRECT);
        busy_d           = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            target_q         <= 32'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            busy_q           <= 1'b0;
            link_we_q        <= 1'b0;
            link_data_q      <= 32'd0;
            misalign_q       <= 1'b0;
            overlap_err_q    <= 1'b0;
            taken_count_q    <= 16'd0;
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            stall_q          <= stall_d;
            busy_q           <= busy_d;
            link_we_q        <= link_we_d;
            link_data_q      <= link_data_d;
            misalign_q       <= misalign_d;
            overlap_err_q    <= overlap_err_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign stall          = stall_q;
    assign busy           = busy_q;
    assign link_we        = link_we_q;
    assign link_data      = link_data_q;
    assign misalign       = misalign_q;
    assign overlap_err    = overlap_err_q;
    assign taken_count    = taken_count_q;

endmodule
